// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the decode hazard scoreboard: instruction classes, the
// tracked-stage entry record and the forward-select encoding.
package hazard_scoreboard_pkg;

    localparam int SB_NREG   = 32;
    localparam int SB_NSTAGE = 3;
    localparam int SB_NLONG  = 2;
    localparam int SB_SW     = $clog2(SB_NSTAGE + 1);

    // Entry dst is kept wide enough for any register file up to 256 entries,
    // so the record type does not depend on the NREG of a given instance.
    localparam int SB_DST_W  = 8;

    // 0 = register file, k = bypass from tracked stage k-1.
    typedef logic [SB_SW-1:0] fwd_sel_t;

    typedef enum logic [1:0] {
        IC_ALU  = 2'd0,
        IC_LOAD = 2'd1,
        IC_LONG = 2'd2,
        IC_RSVD = 2'd3
    } iclass_t;

    // rdy: first stage index whose result can be bypassed (0 = EX, 1 = MEM).
    typedef struct packed {
        logic                valid;
        logic                wr;
        logic [SB_DST_W-1:0] dst;
        logic                rdy;
    } sb_entry_t;

    // Register 0 is hardwired, so a writer of x0 never creates a dependency.
    function automatic logic entry_match(input sb_entry_t e, input logic [SB_DST_W-1:0] r);
        return e.valid && e.wr && (e.dst == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_sb_pipe.sv
// Shift register of in-flight writer records for the stages after decode.
// Holds as a whole on freeze; otherwise shifts and takes a new record (or bubble) at stage 0.
module hazard_sb_pipe
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         freeze,
    input  sb_entry_t                    ins,
    output sb_entry_t [NSTAGE-1:0]       entry
);

    always_ff @(posedge clk) begin
        if (reset) begin
            entry <= '0;
        end else if (!freeze) begin
            entry[0] <= ins;
            for (int s = 1; s < NSTAGE; s++) begin
                entry[s] <= entry[s-1];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: bypass selects per source, decode stall and
// issue, plus tracking of long-latency ops that complete outside the pipe.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int NREG   = 32,
    parameter  int NSTAGE = 3,
    parameter  int NLONG  = 2,
    localparam int RW     = $clog2(NREG),
    localparam int SW     = $clog2(NSTAGE + 1),
    localparam int CW     = $clog2(NLONG + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_ra1,
    input  logic [RW-1:0] id_ra2,
    input  logic [RW-1:0] id_dst,
    input  logic          id_regwrite,
    input  logic [1:0]    id_class,
    input  logic          pipe_freeze,
    input  logic          flush,
    input  logic          long_done,
    input  logic [RW-1:0] long_done_dst,
    output logic          issue,
    output logic          stall,
    output logic [SW-1:0] fwd_sel1,
    output logic [SW-1:0] fwd_sel2,
    output logic          long_full,
    output logic          err
);

    // Handshake: decode offers an instruction with id_valid; it is accepted
    // (issue) on the edge where it is not flushed, not hazard-stalled and the
    // tracked pipe is not frozen. A stalled instruction must be held by decode.

    iclass_t                 cls;
    sb_entry_t [NSTAGE-1:0]  pipe_entry;
    sb_entry_t               pipe_ins;
    logic [NREG-1:0]         busy;
    logic [CW-1:0]           cnt;
    logic [SW:0]             look1;
    logic [SW:0]             look2;
    logic                    haz1;
    logic                    haz2;
    logic                    long_issue;
    logic                    done_hit;

    assign cls = iclass_t'(id_class);

    // Returns {hazard, select}; scanning oldest to youngest lets the youngest writer win.
    function automatic logic [SW:0] src_lookup(input sb_entry_t [NSTAGE-1:0] ent,
                                               input logic [RW-1:0]          r);
        logic [SW:0] res;
        res = '0;
        for (int s = NSTAGE - 1; s >= 0; s--) begin
            if (entry_match(ent[s], SB_DST_W'(r))) begin
                if (s >= int'(ent[s].rdy)) res = {1'b0, SW'(s + 1)};
                else                       res = {1'b1, {SW{1'b0}}};
            end
        end
        return res;
    endfunction

    always_comb begin
        look1    = src_lookup(pipe_entry, id_ra1);
        look2    = src_lookup(pipe_entry, id_ra2);
        fwd_sel1 = look1[SW-1:0];
        fwd_sel2 = look2[SW-1:0];
        // Long units have no bypass path: a busy source waits for the register file.
        haz1     = look1[SW] | busy[id_ra1];
        haz2     = look2[SW] | busy[id_ra2];
        stall    = id_valid & ~flush &
                   (haz1 | haz2 |
                    (id_regwrite & busy[id_dst]) |
                    ((cls == IC_LONG) & long_full));
        issue    = id_valid & ~flush & ~stall & ~pipe_freeze;
    end

    assign long_full  = (cnt == CW'(NLONG));
    assign long_issue = issue & (cls == IC_LONG);
    assign done_hit   = long_done & busy[long_done_dst];

    // Long ops leave decode straight into their unit, so they occupy no pipe slot.
    always_comb begin
        pipe_ins       = '0;
        pipe_ins.valid = issue & (cls != IC_LONG);
        pipe_ins.wr    = id_regwrite;
        pipe_ins.dst   = SB_DST_W'(id_dst);
        pipe_ins.rdy   = (cls == IC_LOAD);
    end

    hazard_sb_pipe #(
        .NSTAGE (NSTAGE)
    ) u_pipe (
        .clk    (clk),
        .reset  (reset),
        .freeze (pipe_freeze),
        .ins    (pipe_ins),
        .entry  (pipe_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (done_hit) begin
                busy[long_done_dst] <= 1'b0;
            end
            // Placed after the clear so a same-register set takes priority.
            if (long_issue && id_regwrite && (id_dst != '0)) begin
                busy[id_dst] <= 1'b1;
            end
            if (long_issue && !done_hit && (cnt != CW'(NLONG))) begin
                cnt <= cnt + 1'b1;
            end else if (!long_issue && done_hit && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (long_done && !busy[long_done_dst]) begin
                err <= 1'b1;
            end
        end
    end

endmodule
